// File: rtl/mem_writeback_if.sv
// Bundle, data-memory and register-file signals of the memory/writeback stage.
// The slave modport is the stage itself; master is its environment.
interface mem_writeback_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              valid_in;
    logic              ready_out;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [31:0]       mem_address;
    logic [31:0]       store_data;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              err;

    modport slave (
        input  valid_in, is_load, is_store, funct3, rd, mem_address, store_data,
        input  dmem_rdata, dmem_ack,
        output ready_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output rf_we, rf_waddr, rf_wdata, err
    );

    modport master (
        output valid_in, is_load, is_store, funct3, rd, mem_address, store_data,
        output dmem_rdata, dmem_ack,
        input  ready_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  rf_we, rf_waddr, rf_wdata, err
    );
endinterface

// File: rtl/mem_writeback.sv
// Memory/writeback stage: performs load/store over a req/ack data-memory port with
// byte-lane steering and extension, then drives the register-file write port.
module mem_writeback #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    mem_writeback_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWb, StErr} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic              err_q, err_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;

    logic [1:0]  off;
    logic        legal;
    logic        aligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        unused_addr;

    assign off         = bus.mem_address[1:0];
    assign unused_addr = ^bus.mem_address[31:ADDR_W+2];

    // Bundle decode: legality, alignment and store-lane steering.
    always_comb begin
        legal = 1'b0;
        if (bus.is_load && !bus.is_store) begin
            legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (bus.is_store && !bus.is_load) begin
            legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
        end
        unique case (bus.funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        lane_be    = 4'b1111;
        lane_wdata = bus.store_data;
        if (bus.is_store) begin
            unique case (bus.funct3[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << off;
                    lane_wdata = {4{bus.store_data[7:0]}};
                end
                2'b01: begin
                    lane_be    = 4'b0011 << off;
                    lane_wdata = {2{bus.store_data[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = bus.store_data;
                end
            endcase
        end
    end

    // Load lane extraction from the latched offset and size.
    always_comb begin
        shifted = bus.dmem_rdata >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    rd_d  = bus.rd;
                    f3_d  = bus.funct3;
                    off_d = off;
                    cnt_d = '0;
                    if (!bus.is_load && !bus.is_store) begin
                        state_d = StWb;
                        if (bus.rd != 5'd0) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = bus.rd;
                            rf_wdata_d = bus.store_data;
                        end
                    end else if (!legal || !aligned) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                        req_d   = 1'b1;
                        we_d    = bus.is_store;
                        addr_d  = bus.mem_address[ADDR_W+1:2];
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end
            end
            StReq: begin
                if (bus.dmem_ack) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWb;
                        if (rd_q != 5'd0) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = rd_q;
                            rf_wdata_d = load_val;
                        end
                    end
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWb:    state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0;
            wdata_q    <= 32'h0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'h0;
            err_q      <= 1'b0;
            rd_q       <= 5'd0;
            f3_q       <= 3'b0;
            off_q      <= 2'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
        end
    end

    assign bus.ready_out  = (state_q == StIdle);
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.err        = err_q;
endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Consumer stage downstream of the execute stage; takes its result bundle: destination register, load/store flags, funct3, memory address and result/store data.
- Performs the data-memory access for loads and stores over a req/ack handshake, with byte-lane steering and sign/zero extension.
- Drives the register-file write port.
- Back-pressures upstream with a ready signal while a transaction is in flight.

Parameters:
- ADDR_W, 8, width of the data-memory word address; word index = mem_address[ADDR_W+1:2].
- TIMEOUT, 16, max cycles in REQ without dmem_ack before abort; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream bundle valid.
- ready_out  out  1  stage can accept; equals (state==IDLE).
- is_load  in  1  bundle is a load (I-type, opcode 0x03).
- is_store  in  1  bundle is a store (S-type).
- funct3  in  3  access size/signedness.
- rd  in  5  destination register.
- mem_address  in  32  byte address from the load/store unit.
- store_data  in  32  store data (stores) or ALU/immediate result (non-memory ops).
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word address.
- dmem_be  out  4  byte enables, bit0 = byte at address offset 0.
- dmem_wdata  out  32  lane-replicated write data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  one-cycle completion.
- rf_we  out  1  register write strobe.
- rf_waddr  out  5  register index.
- rf_wdata  out  32  register data.
- err  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rf_we, rf_waddr, rf_wdata, err.
  - Timeout counter cleared; ready_out=1.
  - Reset mid-transaction abandons it: dmem_req drops immediately, no rf write.
- States: IDLE, REQ, WB, ERR.
- Accept occurs on a rising edge where valid_in & ready_out. The bundle is latched; the next state depends on the bundle:
  - Neither flag set → WB, with rf_wdata=store_data.
  - is_load & is_store both set → ERR.
  - Illegal funct3 → ERR. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010.
  - Misaligned → ERR. Halfword misaligned when addr[0]=1; word misaligned when addr[1:0]≠0. No memory request is issued.
  - Otherwise → REQ, with dmem_req=1, dmem_we=is_store, dmem_addr, dmem_be, dmem_wdata registered and held stable until ack.
- Store lanes (little-endian):
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<addr[1:0], wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
  - Loads drive be=1111.
- REQ:
  - Timeout counter increments each cycle.
  - If dmem_ack at a rising edge: dmem_req←0. A load latches the extracted lane (sign-extended for LB/LH, zero-extended for LBU/LHU) and goes to WB; a store goes to IDLE.
  - If the counter reaches TIMEOUT without ack: dmem_req←0, go to ERR.
  - dmem_ack outside REQ is ignored.
- WB: rf_we=1 for exactly one cycle, suppressed when rd=0; then IDLE.
- ERR: err=1 for exactly one cycle, no rf write; then IDLE.
- Latency from accept edge E0:
  - Non-memory op: rf_we high in cycle E0..E1.
  - Load with ack at edge E1: rf_we high in E1..E2.
  - Back-to-back accepts are possible only from IDLE. Minimum initiation interval: 2 cycles for non-memory ops, 3 cycles for loads.
- rf_waddr/rf_wdata hold their last values when rf_we=0.

Test Plan:
- ALU writeback: valid_in, no flags, rd=5, store_data=0x1234_5678 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; ready_out=0 for 1 cycle; rd=0 repeat → rf_we stays 0.
- Load sign/zero extend: LB addr=0x0000_0103, memory returns 0x80FF_0000 with ack after 3 wait cycles → dmem_addr=0x40, dmem_req high 4 cycles, rf_wdata=0xFFFF_FF80; same with LBU → 0x0000_0080; LH addr=0x102, rdata 0x8001_xxxx → 0xFFFF_8001.
- Store lanes: SB addr=0x0000_0006, data=0xAABB_CCDD → dmem_be=0100, dmem_wdata=0xDDDD_DDDD, dmem_we=1; SH addr=0x2 → be=1100, wdata=0xCCDD_CCDD; no rf_we after ack.
- Misalign/illegal: LW addr=0x...1 → no dmem_req, err pulse 1 cycle, rf_we=0; load funct3=011 → same.
- Timeout: load with ack never asserted, TIMEOUT=16 → dmem_req drops after 16 cycles, err pulses once, returns IDLE (ready_out=1), next bundle accepted normally.
- Reset mid-op: assert rst_n=0 during REQ → dmem_req=0 asynchronously; late ack after release ignored, no rf_we.
